jtag_debug_sysclk_bridge: RTL and testbench
===========================================

Name: jtag_debug_sysclk_bridge

Overview:
Parametrised system-clock side of the CPU JTAG debug module. Samples the virtual-JTAG update strobes (vs_uir, vs_udr), which are asynchronous to clk, through a synchroniser and edge detector. On each data-register update it captures the instruction and shift-register contents into a small command queue. It then presents queued commands to the CPU debug logic with a valid/ready handshake and per-instruction take_action / take_no_action pulses. Unlike the fixed 2-bit-IR / 38-bit-DR predecessor, IR width, DR width, synchroniser depth and queue depth are generic, and back-to-back updates are queued rather than lost.

Parameters:
IR_WIDTH, 2, instruction register width; NUM_INSTR = 2**IR_WIDTH
DR_WIDTH, 38, data register (sr/jdo) width
ACTION_BIT, 37, index in sr selecting action (1) vs no-action (0); must be < DR_WIDTH
SYNC_STAGES, 2, synchroniser flops per strobe; 2..4
DEPTH, 4, command queue entries; power of 2, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
ir_in  in  IR_WIDTH  instruction from JTAG side; stable while vs_uir is high
sr  in  DR_WIDTH  shift register from JTAG side; stable while vs_udr is high
vs_uir  in  1  update-IR strobe, asynchronous level
vs_udr  in  1  update-DR strobe, asynchronous level
act_ready  in  1  consumer accepts head command this cycle
clr_overflow  in  1  clears overflow flag
act_valid  out  1  queue non-empty
act_ir  out  IR_WIDTH  instruction of head command
jdo  out  DR_WIDTH  data of head command
take_action  out  NUM_INSTR  one-hot accept pulse, action bit set
take_no_action  out  NUM_INSTR  one-hot accept pulse, action bit clear
fifo_level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
overflow  out  1  sticky: an update was dropped

Behaviour:
- Reset (async assert, release on clk): sync chains, edge flops, ir_q, queue pointers and level = 0. Outputs: act_valid=0, act_ir=0, jdo=0, take_action=0, take_no_action=0, fifo_level=0, overflow=0.
- Synchroniser: each strobe passes through SYNC_STAGES flops. Edge detect: pulse = sync_out & ~sync_out_d, one clk wide.
- Edge detect is disarmed until SYNC_STAGES+1 edges after reset release, so a strobe held high through reset produces no pulse.
- uir_pulse: ir_q <= ir_in.
- udr_pulse: push {ir_q, sr} into queue. If uir_pulse occurs in the same cycle, the pushed entry uses the old ir_q; ir_q updates afterwards.
- Latency: vs_udr rises and is first sampled at clk edge N; entry is written at edge N+SYNC_STAGES; act_valid is high after that edge. For SYNC_STAGES=2, act_valid is high after edge N+2.
- Queue: no bypass. Head drives act_ir/jdo while act_valid=1; contents hold while act_valid=0.
- Handshake: pop when act_valid & act_ready. act_ready while empty is ignored. act_ir/jdo stay stable until popped.
- Accept pulses, combinational, in the accept cycle only:
  - take_action[act_ir] = act_valid & act_ready & jdo[ACTION_BIT]
  - take_no_action[act_ir] = act_valid & act_ready & ~jdo[ACTION_BIT]
  - All other bits are 0. At most one bit of the two vectors combined is set.
- Full: push while fifo_level==DEPTH with no simultaneous pop drops the entry and sets overflow. Queue contents are unchanged.
- Full with simultaneous pop: push is accepted and level stays DEPTH.
- Push and pop together at any level: level unchanged.
- Pointers wrap modulo DEPTH.
- overflow: sticky. clr_overflow clears it. If a drop and clr_overflow occur in the same cycle, overflow stays 1 (set wins).
- Reset mid-operation: queue is emptied immediately and asynchronously. Pending strobes are discarded.

Test Plan:
- Defaults; reset; vs_uir pulse with ir_in=2'b01; vs_udr pulse with sr=38'h20_0000_0ABC → act_valid high after edge N+2, act_ir=1, jdo=38'h20_0000_0ABC; act_ready=1 for one cycle → take_action=4'b0010 for 1 clk, then act_valid=0, fifo_level=0.
- Same flow with sr[37]=0 → take_no_action=4'b0010, take_action=0.
- act_ready=0; 6 udr pulses sr=1..6 → fifo_level=4, overflow=1; drain → jdo sequence 1,2,3,4, then act_valid=0; pulse clr_overflow → overflow=0.
- Full queue; act_ready=1 in the same cycle as udr_pulse with sr=7 → no overflow, level stays 4, entry 7 is at the tail.
- uir (ir_in=3) and udr coincide after previous ir_q=1 → entry has act_ir=1; next udr entry has act_ir=3.
- vs_udr held high through reset release → no entry, fifo_level=0. Assert reset with 3 entries queued → act_valid=0 immediately, fifo_level=0.

Source files
------------

// File: rtl/jtag_debug_sysclk_bridge.sv
// System-clock side of the CPU JTAG debug bridge.
// Synchronises the update-IR / update-DR strobes into clk, captures
// {instruction, shift register} on every DR update into a small queue, and
// hands queued commands to the debug logic over a valid/ready handshake with
// one-hot take_action / take_no_action pulses on acceptance.
module jtag_debug_sysclk_bridge #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int ACTION_BIT  = 37,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  localparam int NUM_INSTR  = 2 ** IR_WIDTH,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IR_WIDTH-1:0]  ir_in,
  input  logic [DR_WIDTH-1:0]  sr,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic                 act_ready,
  input  logic                 clr_overflow,
  output logic                 act_valid,
  output logic [IR_WIDTH-1:0]  act_ir,
  output logic [DR_WIDTH-1:0]  jdo,
  output logic [NUM_INSTR-1:0] take_action,
  output logic [NUM_INSTR-1:0] take_no_action,
  output logic [LW-1:0]        fifo_level,
  output logic                 overflow
);

  localparam int EW  = IR_WIDTH + DR_WIDTH;
  localparam int ACW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
  logic                   uir_out_d_q, udr_out_d_q;
  logic [ACW-1:0]         arm_cnt_q;
  logic                   armed;
  logic                   uir_pulse, udr_pulse;

  logic [IR_WIDTH-1:0]    ir_q;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q;

  logic                   full, pop, push_ok, drop;
  logic [EW-1:0]          head;

  // Synchroniser chains plus the delayed copy of each chain output for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync_q  <= '0;
      udr_sync_q  <= '0;
      uir_out_d_q <= 1'b0;
      udr_out_d_q <= 1'b0;
    end else begin
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_out_d_q <= uir_sync_q[SYNC_STAGES-1];
      udr_out_d_q <= udr_sync_q[SYNC_STAGES-1];
    end
  end

  // Arming down-counter: a strobe already high at reset release must not look like a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_q <= ACW'(SYNC_STAGES + 1);
    end else if (arm_cnt_q != '0) begin
      arm_cnt_q <= arm_cnt_q - 1'b1;
    end
  end

  assign armed     = (arm_cnt_q == '0);
  assign uir_pulse = armed & uir_sync_q[SYNC_STAGES-1] & ~uir_out_d_q;
  assign udr_pulse = armed & udr_sync_q[SYNC_STAGES-1] & ~udr_out_d_q;

  // Instruction capture; a coincident DR update still queues the previous instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (uir_pulse) begin
      ir_q <= ir_in;
    end
  end

  assign full    = (level_q == LW'(DEPTH));
  assign pop     = act_valid & act_ready;
  assign push_ok = udr_pulse & (~full | pop);
  assign drop    = udr_pulse & full & ~pop;

  // Occupancy: simultaneous push and pop leave the level unchanged, including when full.
  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Queue storage and pointers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {ir_q, sr};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign act_valid  = (level_q != '0);
  assign act_ir     = head[EW-1:DR_WIDTH];
  assign jdo        = head[DR_WIDTH-1:0];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

  // One-hot accept pulses, selected by the head instruction and its action bit.
  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (jdo[ACTION_BIT]) take_action[act_ir]    = 1'b1;
      else                 take_no_action[act_ir] = 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge.sv
// Bench for jtag_debug_sysclk_bridge with default parameters.
// Expected commands are queued when strobes are driven and compared when accepted.
module tb_jtag_debug_sysclk_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir, vs_udr, act_ready, clr_overflow;
  logic        act_valid;
  logic [1:0]  act_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fifo_level;
  logic        overflow;

  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] dr;
  } entry_t;

  entry_t sb[$];
  logic [1:0] ir_model;
  int checks = 0;
  int errors = 0;

  jtag_debug_sysclk_bridge dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .act_ready(act_ready),
    .clr_overflow(clr_overflow), .act_valid(act_valid), .act_ir(act_ir),
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_uir(input logic [1:0] v);
    ir_in = v; vs_uir = 1'b1;
    tick(); tick();
    vs_uir = 1'b0;
    tick(); tick(); tick();
    ir_model = v;
  endtask

  // Queues the expected entry only when the bench's own level count says it fits.
  task automatic strobe_udr(input logic [37:0] d, inout int lvl);
    sr = d; vs_udr = 1'b1;
    if (lvl < 4) begin
      sb.push_back('{ir: ir_model, dr: d});
      lvl++;
    end
    tick(); tick();
    vs_udr = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ir_in = '0; sr = '0; vs_uir = 0; vs_udr = 0;
    act_ready = 0; clr_overflow = 0; ir_model = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({act_valid, act_ir, jdo, take_action, take_no_action, fifo_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b ir=%h jdo=%h ta=%b tna=%b lvl=%0d ovf=%b, want all zero",
               act_valid, act_ir, jdo, take_action, take_no_action, fifo_level, overflow);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_action();
    entry_t e;
    strobe_uir(2'd1);
    sr = 38'h20_0000_0ABC; vs_udr = 1'b1;
    sb.push_back('{ir: ir_model, dr: sr});
    @(posedge clk);  // edge N
    @(negedge clk);
    checks++;
    if (act_valid !== 1'b0) begin errors++; $display("FAIL latency_n: act_valid=%b want 0", act_valid); end
    @(posedge clk);  // edge N+1
    @(negedge clk);
    checks++;
    if (act_valid !== 1'b0) begin errors++; $display("FAIL latency_n1: act_valid=%b want 0", act_valid); end
    @(posedge clk);  // edge N+2
    @(negedge clk);
    checks++;
    if (act_valid !== 1'b1 || act_ir !== 2'd1 || jdo !== 38'h20_0000_0ABC) begin
      errors++;
      $display("FAIL latency_n2: valid=%b ir=%0d jdo=%h want 1/1/200000abc", act_valid, act_ir, jdo);
    end
    vs_udr = 1'b0;
    tick(); act_ready = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (take_action !== 4'b0010 || take_no_action !== 4'b0000 || jdo !== e.dr) begin
      errors++;
      $display("FAIL take_action: ta=%b tna=%b jdo=%h want 0010/0000/%h", take_action, take_no_action, jdo, e.dr);
    end
    tick(); act_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (take_action !== 4'b0 || act_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL after_pop: ta=%b valid=%b lvl=%0d want 0000/0/0", take_action, act_valid, fifo_level);
    end
    tick();
  endtask

  task automatic test_no_action();
    int lvl = 0;
    entry_t e;
    strobe_udr(38'h00_0000_0123, lvl);
    act_ready = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (take_no_action !== 4'b0010 || take_action !== 4'b0000 || act_ir !== e.ir || jdo !== e.dr) begin
      errors++;
      $display("FAIL take_no_action: tna=%b ta=%b ir=%0d jdo=%h want 0010/0000/%0d/%h",
               take_no_action, take_action, act_ir, jdo, e.ir, e.dr);
    end
    tick(); act_ready = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int lvl = 0;
    entry_t e;
    logic [3:0] exp_ta, exp_tna;
    for (int i = 1; i <= 6; i++) strobe_udr(38'(i), lvl);
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_fill: lvl=%0d ovf=%b want 4/1", fifo_level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); act_ready = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      exp_ta  = e.dr[37] ? (4'b1 << e.ir) : 4'b0;
      exp_tna = e.dr[37] ? 4'b0 : (4'b1 << e.ir);
      checks++;
      if (act_valid !== 1'b1 || act_ir !== e.ir || jdo !== e.dr ||
          take_action !== exp_ta || take_no_action !== exp_tna) begin
        errors++;
        $display("FAIL overflow_drain%0d: valid=%b ir=%0d jdo=%h ta=%b tna=%b want ir=%0d jdo=%h ta=%b tna=%b",
                 i, act_valid, act_ir, jdo, take_action, take_no_action, e.ir, e.dr, exp_ta, exp_tna);
      end
      tick(); act_ready = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (act_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_empty: valid=%b ovf=%b want 0/1", act_valid, overflow);
    end
    tick(); clr_overflow = 1'b1;
    tick(); clr_overflow = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: ovf=%b want 0", overflow); end
    tick();
  endtask

  task automatic test_full_pop();
    int lvl = 0;
    entry_t e;
    for (int i = 11; i <= 14; i++) strobe_udr(38'(i), lvl);
    sr = 38'd7; vs_udr = 1'b1;
    sb.push_back('{ir: ir_model, dr: 38'd7});
    @(posedge clk);           // edge N
    @(posedge clk); #1;       // edge N+1, udr pulse now high
    act_ready = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (jdo !== e.dr || take_action !== 4'b0 || take_no_action !== (4'b1 << e.ir) || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_pop_accept: jdo=%h tna=%b lvl=%0d want %h/%b/4", jdo, take_no_action, fifo_level,
               e.dr, 4'b1 << e.ir);
    end
    tick();                   // edge N+2: push and pop together
    act_ready = 1'b0; vs_udr = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_level: lvl=%0d ovf=%b want 4/0", fifo_level, overflow);
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      act_ready = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act_valid !== 1'b1 || act_ir !== e.ir || jdo !== e.dr) begin
        errors++;
        $display("FAIL full_pop_drain%0d: valid=%b ir=%0d jdo=%h want 1/%0d/%h", i, act_valid, act_ir, jdo, e.ir, e.dr);
      end
      tick();
    end
    act_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (act_valid !== 1'b0) begin errors++; $display("FAIL full_pop_empty: valid=%b want 0", act_valid); end
    tick();
  endtask

  task automatic test_ir_coincide();
    int lvl = 0;
    entry_t e;
    ir_in = 2'd3; sr = 38'h15; vs_uir = 1'b1; vs_udr = 1'b1;
    sb.push_back('{ir: ir_model, dr: 38'h15});
    lvl++;
    tick(); tick();
    vs_uir = 1'b0; vs_udr = 1'b0;
    tick(); tick(); tick();
    ir_model = 2'd3;
    strobe_udr(38'h16, lvl);
    for (int i = 0; i < 2; i++) begin
      act_ready = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act_valid !== 1'b1 || act_ir !== e.ir || jdo !== e.dr || take_no_action !== (4'b1 << e.ir)) begin
        errors++;
        $display("FAIL ir_coincide%0d: valid=%b ir=%0d jdo=%h tna=%b want 1/%0d/%h/%b",
                 i, act_valid, act_ir, jdo, take_no_action, e.ir, e.dr, 4'b1 << e.ir);
      end
      tick();
    end
    act_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_strobe();
    int lvl = 0;
    @(posedge clk); #1 reset = 1'b1; sr = 38'h3F; vs_udr = 1'b1;
    repeat (3) tick();
    reset = 1'b0; ir_model = '0;
    repeat (8) tick();
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || act_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe: lvl=%0d valid=%b want 0/0", fifo_level, act_valid);
    end
    vs_udr = 1'b0;
    repeat (4) tick();
    for (int i = 1; i <= 3; i++) strobe_udr(38'(i + 40), lvl);
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd3) begin errors++; $display("FAIL reset_mid_fill: lvl=%0d want 3", fifo_level); end
    @(posedge clk); #3 reset = 1'b1;
    #1;
    checks++;
    if (act_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b lvl=%0d want 0/0", act_valid, fifo_level);
    end
    sb.delete();
    tick(); reset = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_action();
    test_no_action();
    test_overflow();
    test_full_pop();
    test_ir_coincide();
    test_reset_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
